// File: rtl/wb_matrix_pkg.sv
// ---------------------------------------------------------------------------
// wb_matrix_pkg
//   Shared types and helpers for the Wishbone bus matrix.
//   - arb_state_t : per-slave-port arbiter state (IDLE / BUSY)
//   - WB_SEL_W()  : byte-select width for a given data width
//   - rr_pick()   : round-robin winner selection, returns a one-hot vector
//                   sized for the largest supported matrix (MAX_MASTERS)
// ---------------------------------------------------------------------------
package wb_matrix_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_PTR_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int WB_SEL_W(input int dw);
        return dw / 8;
    endfunction

    // Scan the request vector starting at ptr and wrapping modulo n; the
    // first set request wins. Returns all zeros when nobody requests.
    function automatic logic [MAX_MASTERS-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [MAX_PTR_W-1:0]   ptr,
        input int                     n
    );
        logic [MAX_MASTERS-1:0] gnt;
        logic                   found;
        logic [MAX_PTR_W-1:0]   idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            idx = MAX_PTR_W'((int'(ptr) + i) % n);
            if (i < n && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/wb_slave_port_arbiter_rr.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//   Purely combinational round-robin arbiter, shared by the Wishbone, AXI and
//   AHB matrices.
//   Ports:
//     req_i [N_MASTERS]  request vector
//     ptr_i [PTR_W]      index of the highest-priority requester
//     gnt_o [N_MASTERS]  one-hot winner (zero when no request)
// ---------------------------------------------------------------------------
module wb_rr_arbiter
    import wb_matrix_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int PTR_W     = 1
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [PTR_W-1:0]     ptr_i,
    output logic [N_MASTERS-1:0] gnt_o
);

    assign gnt_o = N_MASTERS'(rr_pick(MAX_MASTERS'(req_i), MAX_PTR_W'(ptr_i), N_MASTERS));

endmodule

// File: rtl/wb_slave_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_slave_port_arbiter
//   Arbitration and routing stage in front of one slave port of the Wishbone
//   matrix. Grants one master at a time (round robin), holds the grant for
//   the whole CYC, routes the granted master to the slave and returns
//   ACK/ERR only to that master.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     m_req_i/stb_i/we_i       per-master request (decoder hit & cyc), STB, WE
//     m_adr_i/dat_i/sel_i      flattened per-master address, data, selects
//     m_ack_o/err_o            per-master responses (granted master only)
//     m_dat_o                  slave read data, shared, qualified by ack
//     s_cyc/stb/we/adr/dat/sel_o  slave-side bus
//     s_ack_i/err_i/dat_i      slave response
//     gnt_vector_o             registered one-hot grant, zero when idle
//     timeout_o                watchdog pulse (only with WB_ARB_TIMEOUT_EN)
//
//   Optional feature macro: WB_ARB_TIMEOUT_EN -- adds a stall watchdog that
//   errors out and releases a transfer after TIMEOUT_CYCLES stalled cycles.
// ---------------------------------------------------------------------------
module wb_slave_port_arbiter
    import wb_matrix_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_MASTERS-1:0]               m_req_i,
    input  logic [N_MASTERS-1:0]               m_stb_i,
    input  logic [N_MASTERS-1:0]               m_we_i,
    input  logic [N_MASTERS*AW-1:0]            m_adr_i,
    input  logic [N_MASTERS*DW-1:0]            m_dat_i,
    input  logic [N_MASTERS*WB_SEL_W(DW)-1:0]  m_sel_i,
    output logic [N_MASTERS-1:0]               m_ack_o,
    output logic [N_MASTERS-1:0]               m_err_o,
    output logic [DW-1:0]                      m_dat_o,
    output logic                               s_cyc_o,
    output logic                               s_stb_o,
    output logic                               s_we_o,
    output logic [AW-1:0]                      s_adr_o,
    output logic [DW-1:0]                      s_dat_o,
    output logic [WB_SEL_W(DW)-1:0]            s_sel_o,
    input  logic                               s_ack_i,
    input  logic                               s_err_i,
    input  logic [DW-1:0]                      s_dat_i,
`ifdef WB_ARB_TIMEOUT_EN
    output logic                               timeout_o,
`endif
    output logic [N_MASTERS-1:0]               gnt_vector_o
);

    localparam int SW    = WB_SEL_W(DW);
    localparam int PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    arb_state_t           state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [N_MASTERS-1:0] pick;
    logic [PTR_W-1:0]     g_idx;
    logic                 own;         // granted master still holds its request
    logic                 timeout_hit;

    wb_rr_arbiter #(
        .N_MASTERS (N_MASTERS),
        .PTR_W     (PTR_W)
    ) u_rr (
        .req_i (m_req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    // NOTE: every combinational block assigns defaults first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (gnt_q[i]) g_idx = PTR_W'(i);
        end
    end

    // Reset masks routing in the same cycle, so a reset mid-transfer never
    // returns a response to the master.
    assign own = (state_q == BUSY) && |(m_req_i & gnt_q) && !rst;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stalled;

    assign stalled = own && m_stb_i[g_idx] && !s_ack_i && !s_err_i;
    // The stalled cycle that would bring the count to TIMEOUT_CYCLES is the
    // one that fires the timeout.
    assign timeout_hit = stalled && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_d       = stalled ? cnt_q + CNT_W'(1) : '0;
    assign timeout_o   = timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Slave-side mux and response routing.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (own) begin
            s_cyc_o = !timeout_hit;
            s_stb_o = m_stb_i[g_idx] && !timeout_hit;
            s_we_o  = m_we_i[g_idx];
            s_adr_o = m_adr_i[g_idx*AW +: AW];
            s_dat_o = m_dat_i[g_idx*DW +: DW];
            s_sel_o = m_sel_i[g_idx*SW +: SW];
            // ERR wins over ACK; a watchdog expiry is reported as ERR.
            m_err_o[g_idx] = s_err_i || timeout_hit;
            m_ack_o[g_idx] = s_ack_i && !s_err_i && !timeout_hit;
        end
    end

    assign m_dat_o      = s_dat_i;
    assign gnt_vector_o = gnt_q;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|m_req_i) begin
                    gnt_d   = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!own || timeout_hit) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                    ptr_d   = (int'(g_idx) == N_MASTERS - 1) ? '0 : g_idx + PTR_W'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: doc/wb_slave_port_arbiter.md
Name: wb_slave_port_arbiter

Overview:
- Per-slave arbitration and routing stage of the Wishbone bus matrix: one instance sits in front of each slave port.
- Accepts requests from N_MASTERS master ports, already qualified by the matrix address decoder.
- Grants one master at a time with round-robin fairness and holds the grant for the whole cycle (CYC).
- Routes the granted master's bus to the slave and returns ACK/ERR/read data only to the granted master.
- The grant vector it exports is the one-hot vector the matrix formal properties check for mutual exclusion.

Parameters:
- N_MASTERS, 2, number of master ports (2..8).
- AW, 32, address width.
- DW, 32, data width; SEL width is DW/8.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- m_req_i  in  N_MASTERS  decoder hit AND cyc for each master targeting this slave.
- m_stb_i  in  N_MASTERS  master STB.
- m_we_i  in  N_MASTERS  master WE.
- m_adr_i  in  N_MASTERS*AW  flattened master addresses.
- m_dat_i  in  N_MASTERS*DW  flattened master write data.
- m_sel_i  in  N_MASTERS*DW/8  flattened master byte selects.
- m_ack_o  out  N_MASTERS  ACK routed to the granted master.
- m_err_o  out  N_MASTERS  ERR routed to the granted master.
- m_dat_o  out  DW  slave read data, shared by all masters; qualified by ack.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side control.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_ack_i, s_err_i  in  1 each  slave response.
- s_dat_i  in  DW  slave read data.
- gnt_vector_o  out  N_MASTERS  registered one-hot grant; all zeros when idle.

Behaviour:
- Reset (synchronous, rst=1): all of the following are cleared.
  - gnt_vector_o=0, s_cyc_o=0, s_stb_o=0, state=IDLE.
  - Round-robin pointer set to master 0 (highest priority).
  - m_ack_o=0, m_err_o=0; s_adr_o, s_dat_o, s_sel_o, s_we_o all 0.
- State machine: IDLE, BUSY.
- IDLE:
  - If any m_req_i is set, pick the first requester at or after the pointer, wrapping modulo N_MASTERS.
  - Register the one-hot grant and go to BUSY next cycle. Arbitration latency is 1 cycle from request to s_cyc_o.
- BUSY:
  - s_cyc_o=1.
  - s_stb_o, s_we_o, s_adr_o, s_dat_o and s_sel_o are combinationally muxed from the granted master.
  - m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i, combinational; all other bits are 0.
  - The grant is held across multiple STB beats for as long as m_req_i[g]=1.
- Release:
  - When m_req_i[g] drops, the grant is released; s_cyc_o deasserts that cycle.
  - Pointer becomes g+1, wrapping N_MASTERS-1 -> 0; next state is IDLE.
  - A new grant is issued at the earliest one cycle later, giving at least one idle cycle between owners.
- Masking rules:
  - s_ack_i or s_err_i seen while IDLE is ignored and never routed.
  - A requester that drops m_req_i without being granted is simply skipped.
- Simultaneous events:
  - Release and new requests in the same cycle: the release is processed first, and the new winner is chosen in IDLE using the updated pointer.
  - s_ack_i and s_err_i both high: ERR takes precedence; m_ack_o[g] is suppressed.
- Invariants:
  - popcount(gnt_vector_o) <= 1 in every cycle.
  - gnt_vector_o is nonzero exactly when state==BUSY.
- Reset mid-transfer: the grant is dropped in the same cycle and nothing is routed back to the master.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT_CYCLES+1) bits runs while in BUSY with s_stb_o=1 and no s_ack_i/s_err_i; it clears on any response or on release.
  - When the counter reaches TIMEOUT_CYCLES, the block forces a 1-cycle m_err_o[g], drops s_stb_o and s_cyc_o, and releases the grant (pointer advances).
  - Output timeout_o (1 bit) pulses for the same cycle.
- Undefined: there is no counter and no timeout_o port; a stalled slave holds the grant indefinitely.

Decomposition:
- Shared package wb_matrix_pkg holds:
  - arb_state_t enum {IDLE, BUSY};
  - the function rr_pick(req, ptr), returning a one-hot winner;
  - the constant WB_SEL_W(DW).
- One sub-module, wb_rr_arbiter: request vector plus pointer in, one-hot grant out, combinational. It is reusable by the AXI and AHB matrices.

Test Plan:
- Single master: m_req_i=2'b01 with a 1-beat read, slave ack on the 2nd BUSY cycle, s_dat_i=32'hDEADBEEF -> gnt_vector_o=01 one cycle after the request, m_ack_o=01, m_dat_o=DEADBEEF, gnt returns to 00 after release.
- Contention:
  - After reset, m_req_i=2'b11 and held -> master 0 granted first.
  - After master 0 releases -> master 1 granted after one idle cycle.
  - After master 1 releases with both still requesting -> master 0 again.
- Burst hold: master 1 granted with 4 STB beats and 4 acks while master 0 requests -> gnt stays 10 for all 4 beats; master 0 is granted only after master 1 drops its request.
- Error precedence: s_ack_i=1 and s_err_i=1 in the same cycle -> m_err_o[g]=1, m_ack_o=0.
- Reset mid-transfer: rst=1 during BUSY -> next cycle s_cyc_o=0, gnt=0, pointer=0, no ack routed.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: slave never acks -> on cycle 8 m_err_o[g]=1 and timeout_o=1, then the grant is released.
